pll_reset_sequencer: RTL

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// Power-up sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the 200 MHz logic reset followed by the 400 MHz TDC reset.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 20000,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned STAGE_GAP      = 16
) (
  input  logic       CLKIN,
  input  logic       RESETN,
  input  logic       LOCKED,
  output logic       PLL_RST,
  output logic       LOGIC_RSTN,
  output logic       TDC_RSTN,
  output logic       READY,
  output logic [7:0] LOSS_CNT,
  output logic [7:0] RETRY_CNT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_PLLRST   = 3'd0,
    S_WAITLOCK = 3'd1,
    S_STABLE   = 3'd2,
    S_REL      = 3'd3,
    S_RUN      = 3'd4
  } state_t;

  localparam logic [15:0] PLL_RST_LAST = 16'(PLL_RST_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] GAP_LAST     = 16'(STAGE_GAP - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  sync_q, sync_d;
  logic        pll_rst_q, pll_rst_d;
  logic        logic_rstn_q, logic_rstn_d;
  logic        tdc_rstn_q, tdc_rstn_d;
  logic        ready_q, ready_d;
  logic [7:0]  loss_cnt_q, loss_cnt_d;
  logic [7:0]  retry_cnt_q, retry_cnt_d;
  logic        lock_s;

  // LOCKED is asynchronous; only the second synchronizer stage is ever used.
  assign sync_d = {sync_q[0], LOCKED};
  assign lock_s = sync_q[1];

  always_comb begin
    state_d     = state_q;
    loss_cnt_d  = loss_cnt_q;
    retry_cnt_d = retry_cnt_q;
    case (state_q)
      S_PLLRST: begin
        if (cnt_q == PLL_RST_LAST) state_d = S_WAITLOCK;
      end
      S_WAITLOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_PLLRST;
          if (retry_cnt_q != 8'hff) retry_cnt_d = retry_cnt_q + 8'd1;
        end
      end
      S_STABLE: begin
        if (!lock_s)                     state_d = S_WAITLOCK;
        else if (cnt_q == STABLE_LAST)   state_d = S_REL;
      end
      S_REL, S_RUN: begin
        // A lock loss beats the stage-gap completion in S_REL.
        if (!lock_s) begin
          state_d = S_PLLRST;
          if (loss_cnt_q != 8'hff) loss_cnt_d = loss_cnt_q + 8'd1;
        end else if (state_q == S_REL && cnt_q == GAP_LAST) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_PLLRST;
    endcase
  end

  always_comb begin
    cnt_d        = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
    // Outputs are decoded from the next state so they move on the same edge.
    pll_rst_d    = (state_d == S_PLLRST);
    logic_rstn_d = (state_d == S_REL) || (state_d == S_RUN);
    tdc_rstn_d   = (state_d == S_RUN);
    ready_d      = (state_d == S_RUN);
  end

  always_ff @(posedge CLKIN) begin
    if (!RESETN) begin
      state_q      <= S_PLLRST;
      cnt_q        <= 16'd0;
      sync_q       <= 2'b00;
      pll_rst_q    <= 1'b1;
      logic_rstn_q <= 1'b0;
      tdc_rstn_q   <= 1'b0;
      ready_q      <= 1'b0;
      loss_cnt_q   <= 8'd0;
      retry_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync_q       <= sync_d;
      pll_rst_q    <= pll_rst_d;
      logic_rstn_q <= logic_rstn_d;
      tdc_rstn_q   <= tdc_rstn_d;
      ready_q      <= ready_d;
      loss_cnt_q   <= loss_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
    end
  end

  assign PLL_RST    = pll_rst_q;
  assign LOGIC_RSTN = logic_rstn_q;
  assign TDC_RSTN   = tdc_rstn_q;
  assign READY      = ready_q;
  assign LOSS_CNT   = loss_cnt_q;
  assign RETRY_CNT  = retry_cnt_q;
  assign STATE      = state_q;

endmodule
